pixel_streamer: RTL and testbench

- Transmit-side counterpart of the image-processing chip's load port.
- A host writes one 5-bit pixel per handshake into an internal frame buffer. Once the frame is full and a start pulse arrives, the block streams the frame as 3 pixels per cycle in raster order, without gaps.
- It asserts load_end on the final beat and presents the latched operating mode alongside the data.
- Sits between the host/test harness and the chip's pixel_in0..2 / load_end / mode inputs.

---
 rtl/pixel_stream_pkg.sv | 29 ++
 rtl/pixel_frame_buf.sv | 38 +++
 rtl/pixel_streamer.sv | 123 ++++++++++++
 tb/tb_pixel_streamer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_pkg.sv
// rtl/pixel_stream_pkg.sv - shared constants, state encoding and mode values for the pixel streamer
package pixel_stream_pkg;

    localparam int IMG_DIM    = 20;
    localparam int BIT_LENGTH = 5;
    localparam int TOTAL_PIX  = IMG_DIM * IMG_DIM;
    localparam int BEATS      = (TOTAL_PIX + 2) / 3;
    localparam int LAST_LANES = TOTAL_PIX - 3 * (BEATS - 1);

    localparam int PTR_W  = 9;
    localparam int BEAT_W = 8;

    // Sized forms so comparisons against the 9-bit pointer and 8-bit beat counter stay width-exact
    localparam logic [PTR_W-1:0]  PIX_LIMIT = PTR_W'(TOTAL_PIX);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(TOTAL_PIX - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    // Operating mode as understood by the image-processing chip
    localparam logic MODE_EDGE  = 1'b0;
    localparam logic MODE_COLOR = 1'b1;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_READY  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/pixel_frame_buf.sv
// rtl/pixel_frame_buf.sv - one-frame pixel store with a single write port and a 3-lane read port
module pixel_frame_buf
    import pixel_stream_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_W-1:0]      waddr,
    input  logic [BIT_LENGTH-1:0] wdata,
    input  logic [PTR_W-1:0]      rbase,
    output logic [BIT_LENGTH-1:0] rdata0,
    output logic [BIT_LENGTH-1:0] rdata1,
    output logic [BIT_LENGTH-1:0] rdata2
);

    // Contents are deliberately not reset; a new fill always overwrites every pixel
    logic [BIT_LENGTH-1:0] mem [TOTAL_PIX];

    logic [PTR_W-1:0] idx0;
    logic [PTR_W-1:0] idx1;
    logic [PTR_W-1:0] idx2;

    assign idx0 = rbase;
    assign idx1 = rbase + 9'd1;
    assign idx2 = rbase + 9'd2;

    // Host write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Lanes past the end of the frame read as zero so the short final beat is padded cleanly
    assign rdata0 = (idx0 < PIX_LIMIT) ? mem[idx0] : '0;
    assign rdata1 = (idx1 < PIX_LIMIT) ? mem[idx1] : '0;
    assign rdata2 = (idx2 < PIX_LIMIT) ? mem[idx2] : '0;

endmodule

// File: rtl/pixel_streamer.sv
// rtl/pixel_streamer.sv - buffers one frame from the host and streams it 3 pixels per beat to the chip
module pixel_streamer
    import pixel_stream_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    input  logic [BIT_LENGTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  start,
    input  logic                  mode_sel,
    output logic                  frame_ready,
    output logic                  stream_valid,
    output logic [BIT_LENGTH-1:0] pixel_out0,
    output logic [BIT_LENGTH-1:0] pixel_out1,
    output logic [BIT_LENGTH-1:0] pixel_out2,
    output logic                  load_end,
    output logic                  mode,
    output logic                  done
);

    state_t                state;
    logic [PTR_W-1:0]      wr_ptr;
    logic [BEAT_W-1:0]     beat_cnt;
    logic                  we;
    logic [PTR_W-1:0]      rd_beat;
    logic [PTR_W-1:0]      rd_base;
    logic [BIT_LENGTH-1:0] lane0;
    logic [BIT_LENGTH-1:0] lane1;
    logic [BIT_LENGTH-1:0] lane2;

    assign we = (state == ST_FILL) && wr_valid && wr_ready;

    // beat_cnt names the beat currently on the outputs; the buffer is addressed one beat ahead
    // so each edge can load the next beat. Outside STREAM the address sits on beat 0, ready for start.
    assign rd_beat = (state == ST_STREAM) ? ({1'b0, beat_cnt} + 9'd1) : 9'd0;
    assign rd_base = rd_beat * 9'd3;

    pixel_frame_buf u_frame_buf (
        .clk    (clk),
        .we     (we),
        .waddr  (wr_ptr),
        .wdata  (wr_data),
        .rbase  (rd_base),
        .rdata0 (lane0),
        .rdata1 (lane1),
        .rdata2 (lane2)
    );

    // Frame FSM with registered handshake, lane, and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_FILL;
            wr_ptr       <= '0;
            beat_cnt     <= '0;
            wr_ready     <= 1'b1;
            frame_ready  <= 1'b0;
            stream_valid <= 1'b0;
            pixel_out0   <= '0;
            pixel_out1   <= '0;
            pixel_out2   <= '0;
            load_end     <= 1'b0;
            mode         <= MODE_EDGE;
            done         <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    done <= 1'b0;
                    if (we) begin
                        if (wr_ptr == LAST_PTR) begin
                            state       <= ST_READY;
                            wr_ready    <= 1'b0;
                            frame_ready <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + 9'd1;
                        end
                    end
                end
                ST_READY: begin
                    if (start) begin
                        state        <= ST_STREAM;
                        frame_ready  <= 1'b0;
                        mode         <= mode_sel;
                        beat_cnt     <= '0;
                        stream_valid <= 1'b1;
                        pixel_out0   <= lane0;
                        pixel_out1   <= lane1;
                        pixel_out2   <= lane2;
                        load_end     <= (LAST_BEAT == 8'd0);
                    end
                end
                ST_STREAM: begin
                    if (beat_cnt == LAST_BEAT) begin
                        state        <= ST_DONE;
                        stream_valid <= 1'b0;
                        load_end     <= 1'b0;
                        pixel_out0   <= '0;
                        pixel_out1   <= '0;
                        pixel_out2   <= '0;
                        done         <= 1'b1;
                    end else begin
                        beat_cnt   <= beat_cnt + 8'd1;
                        pixel_out0 <= lane0;
                        pixel_out1 <= lane1;
                        pixel_out2 <= lane2;
                        load_end   <= ((beat_cnt + 8'd1) == LAST_BEAT);
                    end
                end
                ST_DONE: begin
                    done     <= 1'b0;
                    state    <= ST_FILL;
                    wr_ptr   <= '0;
                    beat_cnt <= '0;
                    wr_ready <= 1'b1;
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_streamer.sv
// tb/tb_pixel_streamer.sv - randomized self-checking bench for pixel_streamer
module tb_pixel_streamer;

    localparam int NPIX  = 400;
    localparam int NBEAT = 134;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_valid = 1'b0;
    logic [4:0] wr_data = '0;
    logic       wr_ready;
    logic       start = 1'b0;
    logic       mode_sel = 1'b0;
    logic       frame_ready;
    logic       stream_valid;
    logic [4:0] pixel_out0;
    logic [4:0] pixel_out1;
    logic [4:0] pixel_out2;
    logic       load_end;
    logic       mode;
    logic       done;

    int total = 0;
    int bad = 0;

    logic [4:0] frame [NPIX];

    logic [4:0] cap0 [200];
    logic [4:0] cap1 [200];
    logic [4:0] cap2 [200];
    logic       cap_le [200];
    logic       cap_md [200];
    int         cap_n;
    int         cap_wait;
    logic       post_done;
    logic       post_valid;
    logic       post_le;
    logic [14:0] post_lanes;
    logic       after_wr_ready;
    logic       after_done;

    pixel_streamer dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .start        (start),
        .mode_sel     (mode_sel),
        .frame_ready  (frame_ready),
        .stream_valid (stream_valid),
        .pixel_out0   (pixel_out0),
        .pixel_out1   (pixel_out1),
        .pixel_out2   (pixel_out2),
        .load_end     (load_end),
        .mode         (mode),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pixel index p of the frame, or 0 past the end of the frame
    function automatic logic [4:0] exp_lane(input int b, input int k);
        int idx;
        idx = 3 * b + k;
        return (idx < NPIX) ? frame[idx] : 5'd0;
    endfunction

    function automatic int first_bad_beat(input logic exp_mode);
        for (int b = 0; b < cap_n && b < NBEAT; b++) begin
            if (cap0[b] !== exp_lane(b, 0) || cap1[b] !== exp_lane(b, 1) || cap2[b] !== exp_lane(b, 2)
                || cap_le[b] !== (b == NBEAT - 1) || cap_md[b] !== exp_mode)
                return b;
        end
        return -1;
    endfunction

    task automatic fill(input int start_at, output bit saw_valid);
        saw_valid = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            wr_valid = 1'b1;
            wr_data  = frame[i];
            start    = (i == start_at);
            mode_sel = 1'($urandom);
            tick;
            if (stream_valid) saw_valid = 1'b1;
        end
        wr_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic do_start(input logic m);
        mode_sel = m;
        start    = 1'b1;
        tick;
        start    = 1'b0;
        mode_sel = ~m;
    endtask

    task automatic capture(input int start_at_beat);
        cap_wait = 0;
        while (!stream_valid && cap_wait < 8) begin
            tick;
            cap_wait++;
        end
        cap_n = 0;
        while (stream_valid && cap_n < 200) begin
            cap0[cap_n]   = pixel_out0;
            cap1[cap_n]   = pixel_out1;
            cap2[cap_n]   = pixel_out2;
            cap_le[cap_n] = load_end;
            cap_md[cap_n] = mode;
            start    = (cap_n == start_at_beat);
            mode_sel = 1'($urandom);
            tick;
            start = 1'b0;
            cap_n++;
        end
        post_done  = done;
        post_valid = stream_valid;
        post_le    = load_end;
        post_lanes = {pixel_out0, pixel_out1, pixel_out2};
        tick;
        after_wr_ready = wr_ready;
        after_done     = done;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready); end
        total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL reset_frame_ready got=%b want=0", frame_ready); end
        total++; if ({stream_valid, load_end, done, mode} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {stream_valid, load_end, done, mode}); end
        total++; if ({pixel_out0, pixel_out1, pixel_out2} !== 15'd0) begin bad++; $display("FAIL reset_lanes got=%h want=0", {pixel_out0, pixel_out1, pixel_out2}); end
        reset = 1'b0;
    endtask

    task automatic test_ramp;
        bit sv;
        int fb;
        for (int i = 0; i < NPIX; i++) frame[i] = 5'(i % 32);
        fill(-1, sv);
        total++; if ({wr_ready, frame_ready} !== 2'b01) begin bad++; $display("FAIL ramp_ready got=%b want=01", {wr_ready, frame_ready}); end
        do_start(1'b1);
        capture(-1);
        total++; if (cap_wait !== 0) begin bad++; $display("FAIL ramp_latency got=%0d want=0", cap_wait); end
        total++; if (cap_n !== NBEAT) begin bad++; $display("FAIL ramp_beats got=%0d want=%0d", cap_n, NBEAT); end
        total++; if ({cap0[0], cap1[0], cap2[0]} !== {5'd0, 5'd1, 5'd2}) begin bad++; $display("FAIL ramp_beat0 got=%h want=%h", {cap0[0], cap1[0], cap2[0]}, {5'd0, 5'd1, 5'd2}); end
        total++; if ({cap0[10], cap1[10], cap2[10]} !== {5'd30, 5'd31, 5'd0}) begin bad++; $display("FAIL ramp_beat10 got=%h want=%h", {cap0[10], cap1[10], cap2[10]}, {5'd30, 5'd31, 5'd0}); end
        total++; if ({cap0[133], cap1[133], cap2[133], cap_le[133]} !== {5'd15, 5'd0, 5'd0, 1'b1}) begin bad++; $display("FAIL ramp_beat133 got=%h want=%h", {cap0[133], cap1[133], cap2[133], cap_le[133]}, {5'd15, 5'd0, 5'd0, 1'b1}); end
        fb = first_bad_beat(1'b1);
        total++; if (fb !== -1) begin bad++; $display("FAIL ramp_stream beat=%0d got=%h,%h,%h le=%b md=%b", fb, cap0[fb], cap1[fb], cap2[fb], cap_le[fb], cap_md[fb]); end
        total++; if ({post_done, post_valid, post_le, post_lanes} !== {1'b1, 1'b0, 1'b0, 15'd0}) begin bad++; $display("FAIL ramp_done got=%b want=100 lanes=%h", {post_done, post_valid, post_le}, post_lanes); end
        total++; if ({after_done, after_wr_ready} !== 2'b01) begin bad++; $display("FAIL ramp_refill got=%b want=01", {after_done, after_wr_ready}); end
        total++; if (mode !== 1'b1) begin bad++; $display("FAIL ramp_mode_hold got=%b want=1", mode); end
    endtask

    task automatic test_gapped_writes;
        int acc;
        int fb;
        logic m;
        for (int i = 0; i < NPIX; i++) frame[i] = 5'($urandom);
        acc = 0;
        for (int cyc = 0; cyc < 1200 && acc < NPIX; cyc++) begin
            wr_valid = (cyc % 2 == 1);
            wr_data  = frame[acc];
            total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL gap_wr_ready cyc=%0d got=%b want=1", cyc, wr_ready); end
            if (wr_valid && wr_ready) acc++;
            tick;
        end
        wr_valid = 1'b0;
        total++; if (acc !== NPIX) begin bad++; $display("FAIL gap_accepts got=%0d want=%0d", acc, NPIX); end
        total++; if ({wr_ready, frame_ready} !== 2'b01) begin bad++; $display("FAIL gap_full got=%b want=01", {wr_ready, frame_ready}); end
        wr_valid = 1'b1;
        wr_data  = ~frame[NPIX-1];
        tick;
        wr_valid = 1'b0;
        total++; if ({wr_ready, frame_ready, stream_valid} !== 3'b010) begin bad++; $display("FAIL gap_extra_write got=%b want=010", {wr_ready, frame_ready, stream_valid}); end
        m = 1'($urandom);
        do_start(m);
        capture(-1);
        total++; if (cap_n !== NBEAT) begin bad++; $display("FAIL gap_beats got=%0d want=%0d", cap_n, NBEAT); end
        fb = first_bad_beat(m);
        total++; if (fb !== -1) begin bad++; $display("FAIL gap_stream beat=%0d got=%h,%h,%h le=%b md=%b", fb, cap0[fb], cap1[fb], cap2[fb], cap_le[fb], cap_md[fb]); end
    endtask

    task automatic test_stray_starts;
        bit sv;
        int fb;
        for (int i = 0; i < NPIX; i++) frame[i] = 5'($urandom);
        fill(200, sv);
        total++; if (sv !== 1'b0) begin bad++; $display("FAIL stray_fill_stream got=%b want=0", sv); end
        total++; if ({frame_ready, stream_valid} !== 2'b10) begin bad++; $display("FAIL stray_ready got=%b want=10", {frame_ready, stream_valid}); end
        do_start(1'b0);
        capture(20);
        total++; if (cap_n !== NBEAT) begin bad++; $display("FAIL stray_beats got=%0d want=%0d", cap_n, NBEAT); end
        fb = first_bad_beat(1'b0);
        total++; if (fb !== -1) begin bad++; $display("FAIL stray_stream beat=%0d got=%h,%h,%h le=%b md=%b", fb, cap0[fb], cap1[fb], cap2[fb], cap_le[fb], cap_md[fb]); end
    endtask

    task automatic test_mid_reset;
        bit sv;
        int fb;
        logic m;
        for (int i = 0; i < NPIX; i++) frame[i] = 5'($urandom);
        fill(-1, sv);
        do_start(1'b1);
        repeat (50) tick;
        total++; if ({stream_valid, pixel_out0, pixel_out1, pixel_out2} !== {1'b1, exp_lane(50, 0), exp_lane(50, 1), exp_lane(50, 2)}) begin bad++; $display("FAIL midrst_beat50 got=%h want=%h", {stream_valid, pixel_out0, pixel_out1, pixel_out2}, {1'b1, exp_lane(50, 0), exp_lane(50, 1), exp_lane(50, 2)}); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        total++; if ({stream_valid, load_end, pixel_out0, pixel_out1, pixel_out2} !== 17'd0) begin bad++; $display("FAIL midrst_outputs got=%h want=0", {stream_valid, load_end, pixel_out0, pixel_out1, pixel_out2}); end
        total++; if ({wr_ready, frame_ready} !== 2'b10) begin bad++; $display("FAIL midrst_handshake got=%b want=10", {wr_ready, frame_ready}); end
        for (int i = 0; i < NPIX; i++) frame[i] = 5'($urandom);
        fill(-1, sv);
        m = 1'($urandom);
        do_start(m);
        capture(-1);
        total++; if (cap_n !== NBEAT) begin bad++; $display("FAIL midrst_beats got=%0d want=%0d", cap_n, NBEAT); end
        fb = first_bad_beat(m);
        total++; if (fb !== -1) begin bad++; $display("FAIL midrst_stream beat=%0d got=%h,%h,%h le=%b md=%b", fb, cap0[fb], cap1[fb], cap2[fb], cap_le[fb], cap_md[fb]); end
    endtask

    task automatic test_back_to_back;
        bit sv;
        int fb;
        int off;
        off = int'($urandom_range(0, 31));
        for (int i = 0; i < NPIX; i++) frame[i] = 5'((i + off) % 32);
        fill(-1, sv);
        do_start(1'b1);
        capture(-1);
        fb = first_bad_beat(1'b1);
        total++; if (fb !== -1 || cap_n !== NBEAT) begin bad++; $display("FAIL b2b_frame_a beat=%0d beats=%0d", fb, cap_n); end
        for (int i = 0; i < NPIX; i++) frame[i] = 5'd31;
        fill(-1, sv);
        do_start(1'b0);
        capture(-1);
        total++; if (cap_n !== NBEAT) begin bad++; $display("FAIL b2b_beats got=%0d want=%0d", cap_n, NBEAT); end
        fb = first_bad_beat(1'b0);
        total++; if (fb !== -1) begin bad++; $display("FAIL b2b_frame_b beat=%0d got=%h,%h,%h le=%b md=%b", fb, cap0[fb], cap1[fb], cap2[fb], cap_le[fb], cap_md[fb]); end
        total++; if ({cap0[133], cap1[133], cap2[133]} !== {5'd31, 5'd0, 5'd0}) begin bad++; $display("FAIL b2b_last_beat got=%h want=%h", {cap0[133], cap1[133], cap2[133]}, {5'd31, 5'd0, 5'd0}); end
    endtask

    task automatic test_start_with_last_write;
        bit sv;
        int fb;
        for (int i = 0; i < NPIX; i++) frame[i] = 5'($urandom);
        fill(NPIX - 1, sv);
        total++; if ({frame_ready, stream_valid} !== 2'b10) begin bad++; $display("FAIL lastwr_ignored got=%b want=10", {frame_ready, stream_valid}); end
        tick;
        total++; if ({frame_ready, stream_valid} !== 2'b10) begin bad++; $display("FAIL lastwr_hold got=%b want=10", {frame_ready, stream_valid}); end
        do_start(1'b1);
        total++; if ({stream_valid, pixel_out0} !== {1'b1, frame[0]}) begin bad++; $display("FAIL lastwr_first_beat got=%h want=%h", {stream_valid, pixel_out0}, {1'b1, frame[0]}); end
        capture(-1);
        fb = first_bad_beat(1'b1);
        total++; if (fb !== -1 || cap_n !== NBEAT) begin bad++; $display("FAIL lastwr_stream beat=%0d beats=%0d", fb, cap_n); end
    endtask

    initial begin
        test_reset;
        test_ramp;
        test_gapped_writes;
        test_stray_starts;
        test_mid_reset;
        test_back_to_back;
        test_start_with_last_write;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
